// File: rtl/y_diag_accum_engine.sv
// Multi-lane complex diagonal accumulator: loads NCH diagonals, folds in a stream of
// add/sub terms through a one-stage operand pipeline, then strobes the result out.
module y_diag_accum_engine #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned NCH   = 4,
  parameter bit          SAT   = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 clear,
  input  logic [NCH*WIDTH-1:0] y_diag,
  input  logic [NCH*WIDTH-1:0] y_old,
  input  logic [NCH*WIDTH-1:0] y_new,
  input  logic [1:0]           sel_old_or_new,
  input  logic                 mode_addsub,
  input  logic                 term_valid,
  input  logic                 term_last,
  output logic                 term_ready,
  output logic                 busy,
  output logic                 out_valid,
  output logic [NCH*WIDTH-1:0] y_new_diag,
  output logic [NCH-1:0]       ovf
);

  localparam int unsigned HW = WIDTH / 2;
  localparam int unsigned DW = NCH * WIDTH;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [DW-1:0]  acc_q, acc_d;
  logic [DW-1:0]  op_q, op_d;
  logic [DW-1:0]  ynd_q, ynd_d;
  logic           sub_q, sub_d;
  logic           s1_valid_q, s1_valid_d;
  logic [NCH-1:0] ovf_q, ovf_d;

  logic [DW-1:0]  upd_acc;
  logic [NCH-1:0] upd_ovf;
  logic [DW-1:0]  sel_op;

  // Returns {overflow, result}; overflow is a sign error of the signed add/sub.
  function automatic logic [HW:0] addsub(input logic [HW-1:0] a, input logic [HW-1:0] b,
                                         input logic sub);
    logic [HW-1:0] r;
    logic          o;
    r = sub ? (a - b) : (a + b);
    o = sub ? ((a[HW-1] != b[HW-1]) && (r[HW-1] != a[HW-1]))
            : ((a[HW-1] == b[HW-1]) && (r[HW-1] != a[HW-1]));
    // On overflow the true result always lies on the side of a's sign.
    if (SAT && o) r = a[HW-1] ? {1'b1, {(HW-1){1'b0}}} : {1'b0, {(HW-1){1'b1}}};
    return {o, r};
  endfunction

  always_comb begin
    logic [HW:0] re_r;
    logic [HW:0] im_r;
    upd_acc = '0;
    upd_ovf = '0;
    re_r    = '0;
    im_r    = '0;
    for (int k = 0; k < NCH; k++) begin
      re_r = addsub(acc_q[k*WIDTH+HW +: HW], op_q[k*WIDTH+HW +: HW], sub_q);
      im_r = addsub(acc_q[k*WIDTH +: HW], op_q[k*WIDTH +: HW], sub_q);
      upd_acc[k*WIDTH +: WIDTH] = {re_r[HW-1:0], im_r[HW-1:0]};
      upd_ovf[k] = re_r[HW] | im_r[HW];
    end
  end

  always_comb begin
    unique case (sel_old_or_new)
      2'b00:   sel_op = y_new;
      2'b11:   sel_op = y_old;
      default: sel_op = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    op_d       = op_q;
    sub_d      = sub_q;
    ynd_d      = ynd_q;
    ovf_d      = ovf_q;
    s1_valid_d = 1'b0;

    if (s1_valid_q) begin
      acc_d = upd_acc;
      ovf_d = ovf_q | upd_ovf;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = y_diag;
          ovf_d   = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (term_valid) begin
          s1_valid_d = 1'b1;
          op_d       = sel_op;
          sub_d      = mode_addsub;
          if (term_last) state_d = StDrain;
        end
      end
      StDrain: begin
        ynd_d   = acc_d;
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase

    // Abort discards the in-flight operand without touching results.
    if (clear) begin
      state_d    = StIdle;
      s1_valid_d = 1'b0;
      acc_d      = acc_q;
      ynd_d      = ynd_q;
      ovf_d      = ovf_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      op_q       <= '0;
      sub_q      <= 1'b0;
      ynd_q      <= '0;
      ovf_q      <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      op_q       <= op_d;
      sub_q      <= sub_d;
      ynd_q      <= ynd_d;
      ovf_q      <= ovf_d;
      s1_valid_q <= s1_valid_d;
    end
  end

  assign term_ready = (state_q == StAccum);
  assign busy       = (state_q != StIdle);
  assign out_valid  = (state_q == StDone);
  assign y_new_diag = ynd_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_y_diag_accum_engine.sv
// Bench for y_diag_accum_engine: wrap and saturating instances share stimulus and are
// checked against constant vectors and an integer-arithmetic transaction model.
module tb_y_diag_accum_engine;

  localparam int W  = 48;
  localparam int N  = 4;
  localparam int H  = W / 2;
  localparam int DW = N * W;
  localparam longint MAXV = (longint'(1) <<< (H - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (H - 1));

  logic clock, reset, start, clear, mode_addsub, term_valid, term_last;
  logic [DW-1:0] y_diag, y_old, y_new;
  logic [1:0] sel_old_or_new;
  logic term_ready0, busy0, out_valid0, term_ready1, busy1, out_valid1;
  logic [DW-1:0] ynd0, ynd1;
  logic [N-1:0] ovf0, ovf1;

  y_diag_accum_engine #(.WIDTH(W), .NCH(N), .SAT(1'b0)) dut0 (
    .clock(clock), .reset(reset), .start(start), .clear(clear), .y_diag(y_diag),
    .y_old(y_old), .y_new(y_new), .sel_old_or_new(sel_old_or_new),
    .mode_addsub(mode_addsub), .term_valid(term_valid), .term_last(term_last),
    .term_ready(term_ready0), .busy(busy0), .out_valid(out_valid0),
    .y_new_diag(ynd0), .ovf(ovf0)
  );

  y_diag_accum_engine #(.WIDTH(W), .NCH(N), .SAT(1'b1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .clear(clear), .y_diag(y_diag),
    .y_old(y_old), .y_new(y_new), .sel_old_or_new(sel_old_or_new),
    .mode_addsub(mode_addsub), .term_valid(term_valid), .term_last(term_last),
    .term_ready(term_ready1), .busy(busy1), .out_valid(out_valid1),
    .y_new_diag(ynd1), .ovf(ovf1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state, index 0 = wrapping instance, 1 = saturating instance
  logic [DW-1:0] m_acc [2];
  logic [DW-1:0] m_ynd [2];
  logic [N-1:0]  m_ovf [2];

  typedef struct {
    logic [DW-1:0] yo;
    logic [DW-1:0] yn;
    logic [1:0]    sel;
    bit            sub;
    int            gap;
    bit            poke;
  } term_t;
  term_t tq[$];

  typedef struct {
    logic [H-1:0] dre, dim, ore, oim;
    logic [1:0]   sel;
    bit           sub;
    logic [H-1:0] e0re, e0im;
    bit           e0ovf;
    logic [H-1:0] e1re, e1im;
    bit           e1ovf;
  } vec_t;
  vec_t vt[6];

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_bus();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  // Signed component arithmetic on plain integers; returns {overflow, result}.
  function automatic logic [H:0] comp(input logic [H-1:0] a, input logic [H-1:0] b,
                                      input bit sub, input bit sat);
    longint x, y, r;
    bit ov;
    x = longint'($signed(a));
    y = longint'($signed(b));
    r = sub ? x - y : x + y;
    ov = (r > MAXV) || (r < MINV);
    if (ov && sat) r = (r > MAXV) ? MAXV : MINV;
    return {ov, r[H-1:0]};
  endfunction

  task automatic model_start(input logic [DW-1:0] d);
    for (int s = 0; s < 2; s++) begin
      m_acc[s] = d;
      m_ovf[s] = '0;
    end
  endtask

  task automatic model_term(input term_t t);
    logic [W-1:0] a, o;
    logic [H:0] re, im;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < N; k++) begin
        a = m_acc[s][k*W +: W];
        o = (t.sel == 2'b00) ? t.yn[k*W +: W] : (t.sel == 2'b11) ? t.yo[k*W +: W] : '0;
        re = comp(a[W-1:H], o[W-1:H], t.sub, s == 1);
        im = comp(a[H-1:0], o[H-1:0], t.sub, s == 1);
        m_acc[s][k*W +: W] = {re[H-1:0], im[H-1:0]};
        if (re[H] || im[H]) m_ovf[s][k] = 1'b1;
      end
    end
  endtask

  task automatic chk_ctrl(input string tag, input bit ev, input bit eb, input bit er);
    chk({tag, " out_valid0"}, DW'(out_valid0), DW'(ev));
    chk({tag, " busy0"}, DW'(busy0), DW'(eb));
    chk({tag, " term_ready0"}, DW'(term_ready0), DW'(er));
    chk({tag, " out_valid1"}, DW'(out_valid1), DW'(ev));
    chk({tag, " busy1"}, DW'(busy1), DW'(eb));
    chk({tag, " term_ready1"}, DW'(term_ready1), DW'(er));
  endtask

  task automatic chk_data(input string tag);
    chk({tag, " y_new_diag0"}, ynd0, m_ynd[0]);
    chk({tag, " ovf0"}, DW'(ovf0), DW'(m_ovf[0]));
    chk({tag, " y_new_diag1"}, ynd1, m_ynd[1]);
    chk({tag, " ovf1"}, DW'(ovf1), DW'(m_ovf[1]));
  endtask

  task automatic chk_zero(input string tag);
    chk_ctrl(tag, 1'b0, 1'b0, 1'b0);
    chk({tag, " y_new_diag0"}, ynd0, '0);
    chk({tag, " ovf0"}, DW'(ovf0), '0);
    chk({tag, " y_new_diag1"}, ynd1, '0);
    chk({tag, " ovf1"}, DW'(ovf1), '0);
  endtask

  task automatic start_txn(input logic [DW-1:0] d);
    chk_ctrl("idle", 1'b0, 1'b0, 1'b0);
    term_valid = 1'b1;
    term_last  = 1'b1;
    y_new      = rnd_bus();
    tick();
    chk_ctrl("idle_term", 1'b0, 1'b0, 1'b0);
    term_valid = 1'b0;
    term_last  = 1'b0;
    start      = 1'b1;
    y_diag     = d;
    model_start(d);
    tick();
    start  = 1'b0;
    y_diag = rnd_bus();
  endtask

  task automatic send_term(input term_t t, input bit last);
    for (int g = 0; g < t.gap; g++) begin
      term_valid = 1'b0;
      y_old      = rnd_bus();
      chk_ctrl("gap", 1'b0, 1'b1, 1'b1);
      tick();
    end
    chk_ctrl("term", 1'b0, 1'b1, 1'b1);
    term_valid     = 1'b1;
    term_last      = last;
    y_old          = t.yo;
    y_new          = t.yn;
    sel_old_or_new = t.sel;
    mode_addsub    = t.sub;
    if (t.poke) begin
      start  = 1'b1;
      y_diag = rnd_bus();
    end
    tick();
    start = 1'b0;
  endtask

  task automatic run_txn(input logic [DW-1:0] d);
    start_txn(d);
    for (int i = 0; i < tq.size(); i++) begin
      send_term(tq[i], i == tq.size() - 1);
      model_term(tq[i]);
    end
    // Terms and start during drain/done must be ignored
    term_valid = 1'b1;
    term_last  = 1'b1;
    y_new      = rnd_bus();
    start      = 1'b1;
    chk_ctrl("drain", 1'b0, 1'b1, 1'b0);
    tick();
    m_ynd[0] = m_acc[0];
    m_ynd[1] = m_acc[1];
    chk_ctrl("done", 1'b1, 1'b1, 1'b0);
    chk_data("done");
    tick();
    term_valid = 1'b0;
    term_last  = 1'b0;
    start      = 1'b0;
    chk_ctrl("post", 1'b0, 1'b0, 1'b0);
    chk_data("post");
    tq.delete();
  endtask

  function automatic term_t rnd_term(input int maxgap);
    term_t t;
    t.yo   = rnd_bus();
    t.yn   = rnd_bus();
    t.sel  = 2'($urandom_range(0, 3));
    t.sub  = 1'($urandom_range(0, 1));
    t.gap  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, maxgap);
    t.poke = ($urandom_range(0, 9) == 0);
    return t;
  endfunction

  initial begin
    term_t t;
    logic [DW-1:0] d;

    vt[0] = '{24'h00000A, 24'hFFFFFB, 24'h000003, 24'h000004, 2'b00, 1'b0,
              24'h00000D, 24'hFFFFFF, 1'b0, 24'h00000D, 24'hFFFFFF, 1'b0};
    vt[1] = '{24'h7FFFFF, 24'h000000, 24'h000001, 24'h000000, 2'b00, 1'b0,
              24'h800000, 24'h000000, 1'b1, 24'h7FFFFF, 24'h000000, 1'b1};
    vt[2] = '{24'h800000, 24'h000005, 24'h000001, 24'h000005, 2'b11, 1'b1,
              24'h7FFFFF, 24'h000000, 1'b1, 24'h800000, 24'h000000, 1'b1};
    vt[3] = '{24'h000000, 24'h000000, 24'h800000, 24'h000000, 2'b11, 1'b1,
              24'h800000, 24'h000000, 1'b1, 24'h7FFFFF, 24'h000000, 1'b1};
    vt[4] = '{24'h000064, 24'h0000C8, 24'h000032, 24'h00012C, 2'b01, 1'b0,
              24'h000064, 24'h0000C8, 1'b0, 24'h000064, 24'h0000C8, 1'b0};
    vt[5] = '{24'hFFFFFF, 24'h400000, 24'hFFFFFF, 24'h400000, 2'b10, 1'b0,
              24'hFFFFFF, 24'h400000, 1'b0, 24'hFFFFFF, 24'h400000, 1'b0};

    reset = 1'b0;
    start = 1'b0; clear = 1'b0; term_valid = 1'b0; term_last = 1'b0;
    mode_addsub = 1'b0; sel_old_or_new = 2'b00;
    y_diag = '0; y_old = '0; y_new = '0;
    for (int s = 0; s < 2; s++) begin
      m_acc[s] = '0; m_ynd[s] = '0; m_ovf[s] = '0;
    end

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom()); clear = 1'($urandom()); term_valid = 1'($urandom());
      term_last = 1'($urandom()); mode_addsub = 1'($urandom());
      sel_old_or_new = 2'($urandom()); y_diag = rnd_bus(); y_old = rnd_bus();
      y_new = rnd_bus();
      tick();
      chk_zero("reset");
    end
    start = 1'b0; clear = 1'b0; term_valid = 1'b0; term_last = 1'b0;
    reset = 1'b1;
    tick();

    // Two-term example on lane 0
    t.gap = 0; t.poke = 0;
    t.yo = '0; t.yo[W-1:0] = rnd_bus();
    t.yn = '0; t.yn[W-1:0] = {24'h000003, 24'h000004};
    t.sel = 2'b00; t.sub = 1'b0;
    tq.push_back(t);
    t.yn = '0; t.yn[W-1:0] = rnd_bus();
    t.yo = '0; t.yo[W-1:0] = {24'h000001, 24'h000001};
    t.sel = 2'b11; t.sub = 1'b1;
    tq.push_back(t);
    d = '0; d[W-1:0] = {24'h00000A, 24'hFFFFFB};
    run_txn(d);
    chk("ex2 lane0 sat0", DW'(ynd0[W-1:0]), DW'({24'h00000C, 24'hFFFFFE}));
    chk("ex2 lane0 sat1", DW'(ynd1[W-1:0]), DW'({24'h00000C, 24'hFFFFFE}));
    chk("ex2 ovf", DW'({ovf1, ovf0}), '0);

    // Single-term vector table on lane 0
    for (int i = 0; i < 6; i++) begin
      t.yo = rnd_bus(); t.yo[W-1:0] = {vt[i].ore, vt[i].oim};
      t.yn = rnd_bus(); t.yn[W-1:0] = {vt[i].ore, vt[i].oim};
      t.sel = vt[i].sel; t.sub = vt[i].sub; t.gap = 0; t.poke = 0;
      tq.push_back(t);
      d = rnd_bus(); d[W-1:0] = {vt[i].dre, vt[i].dim};
      run_txn(d);
      chk($sformatf("vec%0d lane0 sat0", i), DW'(ynd0[W-1:0]), DW'({vt[i].e0re, vt[i].e0im}));
      chk($sformatf("vec%0d ovf0 sat0", i), DW'(ovf0[0]), DW'(vt[i].e0ovf));
      chk($sformatf("vec%0d lane0 sat1", i), DW'(ynd1[W-1:0]), DW'({vt[i].e1re, vt[i].e1im}));
      chk($sformatf("vec%0d ovf0 sat1", i), DW'(ovf1[0]), DW'(vt[i].e1ovf));
    end

    // Eight back-to-back terms with a start poked mid-stream
    for (int i = 0; i < 8; i++) begin
      t = rnd_term(0);
      t.gap = 0;
      t.poke = (i == 3);
      tq.push_back(t);
    end
    run_txn(rnd_bus());

    // Clear one cycle after the third term: terms 1 and 2 land, term 3 is flushed
    start_txn(rnd_bus());
    for (int i = 0; i < 3; i++) begin
      t = rnd_term(0);
      t.gap = 0; t.poke = 0;
      send_term(t, 1'b0);
      if (i < 2) model_term(t);
    end
    term_valid = 1'b0;
    clear = 1'b1;
    chk_ctrl("pre_clear", 1'b0, 1'b1, 1'b1);
    tick();
    clear = 1'b0;
    chk_ctrl("clear", 1'b0, 1'b0, 1'b0);
    chk_data("clear");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ctrl("after_clear", 1'b0, 1'b0, 1'b0);
    end

    // Start and clear together in IDLE: clear wins
    start = 1'b1; clear = 1'b1; y_diag = rnd_bus();
    tick();
    start = 1'b0; clear = 1'b0;
    chk_ctrl("start_clear", 1'b0, 1'b0, 1'b0);
    chk_data("start_clear");

    for (int i = 0; i < 3; i++) tq.push_back(rnd_term(2));
    run_txn(rnd_bus());

    // Reset asserted during DRAIN
    t = rnd_term(0); t.gap = 0; t.poke = 0;
    start_txn(rnd_bus());
    send_term(t, 1'b1);
    term_valid = 1'b0; term_last = 1'b0;
    chk_ctrl("drain_rst", 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    chk_zero("async_rst");
    tick();
    tick();
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      m_ynd[s] = '0; m_ovf[s] = '0;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ctrl("after_rst", 1'b0, 1'b0, 1'b0);
    end
    chk_data("after_rst");

    // Randomized transactions
    for (int n = 0; n < 20; n++) begin
      int nt;
      nt = $urandom_range(1, 8);
      for (int i = 0; i < nt; i++) tq.push_back(rnd_term(2));
      run_txn(rnd_bus());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
